// File: rtl/elevator_ctrl_pkg.sv
// Shared types, direction constants and request-scan helpers for the elevator controller.
// Helpers scan a pending vector zero-extended to MAX_FLOORS bits.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
    } elev_state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    localparam int unsigned MAX_FLOORS = 64;

    function automatic logic any_above(input logic [MAX_FLOORS-1:0] pending,
                                       input int unsigned floor);
        return (pending >> (floor + 1)) != '0;
    endfunction

    function automatic logic any_below(input logic [MAX_FLOORS-1:0] pending,
                                       input int unsigned floor);
        logic [MAX_FLOORS-1:0] mask;
        mask = (MAX_FLOORS'(1) << floor) - MAX_FLOORS'(1);
        return (pending & mask) != '0;
    endfunction

endpackage

// File: rtl/elevator_ctrl_if.sv
// Call-button / car-status bundle between the request synchroniser and the elevator controller.
// ELEVATOR_ESTOP_EN adds the emergency-stop input.
interface elevator_ctrl_if #(
    parameter int unsigned FLOORS = 8
);
    localparam int unsigned FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

    logic [FLOORS-1:0] req;
    logic [FW-1:0]     floor;
    logic              dir;
    logic              moving;
    logic              door_open;
    logic [FLOORS-1:0] pending;
`ifdef ELEVATOR_ESTOP_EN
    logic              estop;
`endif

`ifdef ELEVATOR_ESTOP_EN
    modport master (
        input  req, estop,
        output floor, dir, moving, door_open, pending
    );

    modport slave (
        output req, estop,
        input  floor, dir, moving, door_open, pending
    );
`else
    modport master (
        input  req,
        output floor, dir, moving, door_open, pending
    );

    modport slave (
        output req,
        input  floor, dir, moving, door_open, pending
    );
`endif

endinterface

// File: rtl/elev_timer.sv
// Wrapping cycle counter: counts 0..CYCLES-1, done flags the last count.
// start forces zero and has priority over hold.
module elev_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic hold,
    output logic done
);
    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] count_q;

    assign done = (count_q == CW'(CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (start) begin
            count_q <= '0;
        end else if (!hold) begin
            if (done) begin
                count_q <= '0;
            end else begin
                count_q <= count_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/elevator_ctrl.sv
// Collective elevator car controller: latches calls, keeps direction while calls lie ahead,
// steps one floor per MOVE_CYCLES and holds the door DOOR_CYCLES. ELEVATOR_ESTOP_EN adds estop.
module elevator_ctrl
    import elevator_pkg::*;
#(
    parameter int unsigned FLOORS      = 8,
    parameter int unsigned MOVE_CYCLES = 16,
    parameter int unsigned DOOR_CYCLES = 32
) (
    input logic            clk,
    input logic            rst,
    elevator_ctrl_if.master bus
);
    localparam int unsigned FW = (FLOORS > 1) ? $clog2(FLOORS) : 1;

    elev_state_t       state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d, step_floor;
    logic              dir_q, dir_d;
    logic [FLOORS-1:0] pend_q, clr;
    logic              moving_q, door_q;
    logic              freeze;
    logic              above, below, beyond;
    logic              mv_start, mv_done;
    logic              dr_start, dr_done;

`ifdef ELEVATOR_ESTOP_EN
    assign freeze = bus.estop;
`else
    assign freeze = 1'b0;
`endif

    assign above = any_above(MAX_FLOORS'(pend_q), 32'(floor_q));
    assign below = any_below(MAX_FLOORS'(pend_q), 32'(floor_q));

    // Saturate at the shaft ends even though direction logic never asks to leave them.
    always_comb begin
        if (dir_q == DIR_UP) begin
            step_floor = (floor_q == FW'(FLOORS - 1)) ? floor_q : floor_q + FW'(1);
        end else begin
            step_floor = (floor_q == '0) ? floor_q : floor_q - FW'(1);
        end
    end

    assign beyond = (dir_q == DIR_UP) ? any_above(MAX_FLOORS'(pend_q), 32'(step_floor))
                                      : any_below(MAX_FLOORS'(pend_q), 32'(step_floor));

    always_comb begin
        state_d  = state_q;
        floor_d  = floor_q;
        dir_d    = dir_q;
        clr      = '0;
        mv_start = 1'b0;
        dr_start = 1'b0;
        if (!freeze) begin
            unique case (state_q)
                IDLE: begin
                    if (pend_q[floor_q]) begin
                        state_d        = DOOR;
                        clr[floor_q]   = 1'b1;
                        dr_start       = 1'b1;
                    end else if (above || below) begin
                        if (dir_q == DIR_UP) begin
                            dir_d = above ? DIR_UP : DIR_DN;
                        end else begin
                            dir_d = below ? DIR_DN : DIR_UP;
                        end
                        state_d  = MOVE;
                        mv_start = 1'b1;
                    end
                end
                MOVE: begin
                    if (mv_done) begin
                        floor_d = step_floor;
                        if (pend_q[step_floor]) begin
                            state_d         = DOOR;
                            clr[step_floor] = 1'b1;
                            dr_start        = 1'b1;
                        end else if (!beyond) begin
                            state_d = IDLE;
                        end
                    end
                end
                DOOR: begin
                    // A fresh call at this floor re-arms the door instead of queueing a revisit.
                    if (pend_q[floor_q]) begin
                        clr[floor_q] = 1'b1;
                        dr_start     = 1'b1;
                    end else if (dr_done) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    elev_timer #(
        .CYCLES(MOVE_CYCLES)
    ) u_move_timer (
        .clk  (clk),
        .rst  (rst),
        .start(mv_start),
        .hold (freeze || (state_q != MOVE)),
        .done (mv_done)
    );

    elev_timer #(
        .CYCLES(DOOR_CYCLES)
    ) u_door_timer (
        .clk  (clk),
        .rst  (rst),
        .start(dr_start),
        .hold (freeze || (state_q != DOOR)),
        .done (dr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            floor_q  <= '0;
            dir_q    <= DIR_UP;
            pend_q   <= '0;
            moving_q <= 1'b0;
            door_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            floor_q  <= floor_d;
            dir_q    <= dir_d;
            pend_q   <= (pend_q | bus.req) & ~clr;
            moving_q <= (state_d == MOVE);
            door_q   <= (state_d == DOOR);
        end
    end

    assign bus.floor     = floor_q;
    assign bus.dir       = dir_q;
    assign bus.moving    = moving_q;
    assign bus.door_open = door_q;
    assign bus.pending   = pend_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scoreboard bench for elevator_ctrl: an event-level car model predicts every floor, door and
// motion change with its cycle stamp; a monitor pops and compares when the DUT shows a change.
module tb_elevator_ctrl;
    localparam int FLOORS = 8;
    localparam int MOVE   = 4;
    localparam int DOOR   = 3;
    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    elevator_ctrl_if #(.FLOORS(FLOORS)) bus ();

    elevator_ctrl #(
        .FLOORS     (FLOORS),
        .MOVE_CYCLES(MOVE),
        .DOOR_CYCLES(DOOR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int est_left = 0;

    // Reference car: position, direction, activity and a countdown of cycles left in it.
    int m_floor = 0;
    int m_dir   = 1;
    int m_mode  = M_IDLE;
    int m_left  = 0;
    bit m_pend[FLOORS];
    logic [63:0] exp_q[$];

    function automatic logic [63:0] pack(int kind, int fl, bit d, bit mv, bit dr,
                                         logic [7:0] p, int c);
        return {8'(kind), 8'(fl), 4'(d), 4'(mv), 4'(dr), p, 28'(c)};
    endfunction

    function automatic logic [7:0] pend_vec();
        logic [7:0] v;
        for (int i = 0; i < FLOORS; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic bit has_above(int f);
        for (int i = f + 1; i < FLOORS; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit has_below(int f);
        for (int i = 0; i < f; i++) if (m_pend[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        int  of;
        bit  omv, odr, frozen;
        bit  served[FLOORS];
        if (rst) begin
            m_floor = 0;
            m_dir   = 1;
            m_mode  = M_IDLE;
            m_left  = 0;
            for (int i = 0; i < FLOORS; i++) m_pend[i] = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            of  = m_floor;
            omv = (m_mode == M_MOVE);
            odr = (m_mode == M_DOOR);
            for (int i = 0; i < FLOORS; i++) served[i] = 1'b0;
            frozen = 1'b0;
`ifdef ELEVATOR_ESTOP_EN
            frozen = bus.estop;
`endif
            if (!frozen) begin
                case (m_mode)
                    M_IDLE: begin
                        if (m_pend[m_floor]) begin
                            served[m_floor] = 1'b1;
                            m_mode = M_DOOR;
                            m_left = DOOR;
                        end else if (has_above(m_floor) || has_below(m_floor)) begin
                            if (m_dir == 1) m_dir = has_above(m_floor) ? 1 : 0;
                            else            m_dir = has_below(m_floor) ? 0 : 1;
                            m_mode = M_MOVE;
                            m_left = MOVE;
                        end
                    end
                    M_MOVE: begin
                        m_left--;
                        if (m_left == 0) begin
                            m_floor = m_floor + ((m_dir == 1) ? 1 : -1);
                            if (m_floor < 0) m_floor = 0;
                            if (m_floor > FLOORS - 1) m_floor = FLOORS - 1;
                            if (m_pend[m_floor]) begin
                                served[m_floor] = 1'b1;
                                m_mode = M_DOOR;
                                m_left = DOOR;
                            end else if ((m_dir == 1) ? has_above(m_floor)
                                                      : has_below(m_floor)) begin
                                m_left = MOVE;
                            end else begin
                                m_mode = M_IDLE;
                            end
                        end
                    end
                    default: begin
                        if (m_pend[m_floor]) begin
                            served[m_floor] = 1'b1;
                            m_left = DOOR;
                        end else begin
                            m_left--;
                            if (m_left == 0) m_mode = M_IDLE;
                        end
                    end
                endcase
            end
            for (int i = 0; i < FLOORS; i++)
                m_pend[i] = (m_pend[i] | bus.req[i]) & ~served[i];
            if (m_floor != of)
                exp_q.push_back(pack(0, m_floor, m_dir[0], m_mode == M_MOVE, m_mode == M_DOOR,
                                     pend_vec(), cyc));
            if ((m_mode == M_DOOR) != odr)
                exp_q.push_back(pack(1, m_floor, m_dir[0], m_mode == M_MOVE, m_mode == M_DOOR,
                                     pend_vec(), cyc));
            if ((m_mode == M_MOVE) != omv)
                exp_q.push_back(pack(2, m_floor, m_dir[0], m_mode == M_MOVE, m_mode == M_DOOR,
                                     pend_vec(), cyc));
        end
    end

    logic [2:0] p_floor = '0;
    logic       p_door  = 1'b0;
    logic       p_mov   = 1'b0;

    task automatic see_event(int kind);
        logic [63:0] act;
        act = pack(kind, int'(bus.floor), bus.dir, bus.moving, bus.door_open, bus.pending, cyc);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got %h expected none (cycle %0d)", act, cyc);
        end else begin
            check("event", act, exp_q.pop_front());
        end
    endtask

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            p_floor = '0;
            p_door  = 1'b0;
            p_mov   = 1'b0;
        end else begin
            if (bus.floor != p_floor)    see_event(0);
            if (bus.door_open != p_door) see_event(1);
            if (bus.moving != p_mov)     see_event(2);
            p_floor = bus.floor;
            p_door  = bus.door_open;
            p_mov   = bus.moving;
        end
    end

    task automatic pulse(logic [7:0] r);
        @(negedge clk);
        bus.req = r;
        @(negedge clk);
        bus.req = '0;
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        while (!(m_mode == M_IDLE && pend_vec() == 8'h00) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: model still busy after %0d cycles", tag, n);
        end
        @(negedge clk);
        check({tag, "_idle"}, 64'({bus.moving, bus.door_open, bus.pending}), 64'd0);
    endtask

    task automatic wait_until(string tag, int fl, bit need_door);
        int n;
        n = 0;
        while (!(int'(bus.floor) == fl && (!need_door || bus.door_open)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: floor %0d not reached, at %0d", tag, fl, bus.floor);
        end
    endtask

    task automatic check_reset_values(string tag);
        check({tag, "_floor"},   64'(bus.floor),     64'd0);
        check({tag, "_dir"},     64'(bus.dir),       64'd1);
        check({tag, "_moving"},  64'(bus.moving),    64'd0);
        check({tag, "_door"},    64'(bus.door_open), 64'd0);
        check({tag, "_pending"}, 64'(bus.pending),   64'd0);
    endtask

    initial begin
        bus.req = '0;
`ifdef ELEVATOR_ESTOP_EN
        bus.estop = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_values("reset");

        // Call at the resting floor: door two edges later, three cycles wide.
        pulse(8'h01);
        drain("same_floor");

        // Three floors up.
        pulse(8'h08);
        drain("up3");
        check("up3_floor", 64'(bus.floor), 64'd3);
        check("up3_dir",   64'(bus.dir),   64'd1);

        // Opposite call while travelling up: serve 6 first, then reverse to 2.
        pulse(8'h40);
        wait_until("sweep", 4, 1'b0);
        pulse(8'h04);
        drain("sweep");
        check("sweep_floor", 64'(bus.floor), 64'd2);
        check("sweep_dir",   64'(bus.dir),   64'd0);

        // Re-request while the door is open holds it longer.
        pulse(8'h20);
        wait_until("rereq", 5, 1'b1);
        @(negedge clk);
        pulse(8'h20);
        drain("rereq");
        check("rereq_floor", 64'(bus.floor), 64'd5);

        // Reset in the middle of a move with calls outstanding.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse(8'h90);
        wait_until("rst_mid", 2, 1'b0);
        @(negedge clk);
        check("rst_mid_pending", 64'(bus.pending), 64'h90);
        check("rst_mid_moving",  64'(bus.moving),  64'd1);
        #2 rst = 1'b1;
        #1 check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_after");

        // Random calls (and stop windows when the feature is built in).
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 24) == 0) bus.req = 8'($urandom) & 8'($urandom);
            else                            bus.req = '0;
`ifdef ELEVATOR_ESTOP_EN
            if (est_left > 0) begin
                est_left--;
                bus.estop = 1'b1;
            end else begin
                bus.estop = 1'b0;
                if ($urandom_range(0, 99) == 0) est_left = int'($urandom_range(1, 12));
            end
`endif
        end
        bus.req = '0;
`ifdef ELEVATOR_ESTOP_EN
        bus.estop = 1'b0;
`endif
        drain("random");
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
